// File: rtl/mole_scheduler.sv
// mole_scheduler: raises one pseudo-random mole at a time, times its up/rest windows, scores hits and misses.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   ms_tick            one-clk pulse per millisecond
//   game_in_progress   level, high while a round runs
//   buttons            synchronized button levels, 1 = pressed
//   mole_mask          one-hot raised mole, 0 when none
//   score              saturating hit count for the current/last round
//   hit_pulse          one-clk pulse on a hit
//   miss_pulse         one-clk pulse on a wrong press or an escaped mole
//   mole_up            high while a mole is raised
module mole_scheduler #(
    parameter int          NUM_HOLES    = 4,
    parameter int          MOLE_UP_MS   = 1000,
    parameter int          MOLE_DOWN_MS = 1000,
    parameter int          SCORE_W      = 8,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ms_tick,
    input  logic                 game_in_progress,
    input  logic [NUM_HOLES-1:0] buttons,
    output logic [NUM_HOLES-1:0] mole_mask,
    output logic [SCORE_W-1:0]   score,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 mole_up
);
    localparam int IDX_W  = $clog2(NUM_HOLES);
    localparam int MAX_MS = (MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS;
    localparam int CW     = $clog2(MAX_MS + 1);

    typedef enum logic [1:0] {IDLE, PICK, UP, DOWN} state_t;

    state_t               state, state_n;
    logic [15:0]          lfsr, lfsr_n;
    logic [NUM_HOLES-1:0] btn_q, press, mask_n;
    logic [IDX_W-1:0]     prev_idx, prev_n, lraw, raw, idx;
    logic [CW-1:0]        cnt, cnt_n;
    logic [SCORE_W-1:0]   score_n;
    logic                 hit_n, miss_n, hit, wrong;

    always_comb begin
        press  = buttons & ~btn_q;
        // Galois right-shift form of x^16+x^14+x^13+x^11+1
        lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        lraw   = lfsr[IDX_W-1:0];
        raw    = ({1'b0, lraw} >= (IDX_W+1)'(NUM_HOLES)) ? lraw - IDX_W'(NUM_HOLES) : lraw;
        // bump a repeat to the next hole so the same hole never appears twice in a row
        idx    = (raw != prev_idx) ? raw : (raw == IDX_W'(NUM_HOLES - 1)) ? '0 : raw + 1'b1;
        hit    = |(press & mole_mask);
        wrong  = |(press & ~mole_mask);
        state_n = state;
        cnt_n   = cnt;
        prev_n  = prev_idx;
        score_n = score;
        hit_n   = 1'b0;
        miss_n  = 1'b0;
        case (state)
            IDLE: begin
                if (game_in_progress) begin
                    score_n = '0;
                    state_n = PICK;
                end
            end
            PICK: begin
                prev_n  = idx;
                cnt_n   = CW'(MOLE_UP_MS - 1);
                state_n = UP;
            end
            UP: begin
                if (hit) begin
                    hit_n   = 1'b1;
                    score_n = (score == '1) ? score : score + 1'b1;
                    cnt_n   = CW'(MOLE_DOWN_MS - 1);
                    state_n = DOWN;
                end else if (wrong) begin
                    // the mole stays up; a tick landing on an expired counter is not allowed to wrap it
                    miss_n = 1'b1;
                    cnt_n  = (ms_tick && cnt != '0) ? cnt - 1'b1 : cnt;
                end else if (ms_tick && cnt == '0) begin
                    miss_n  = 1'b1;
                    cnt_n   = CW'(MOLE_DOWN_MS - 1);
                    state_n = DOWN;
                end else if (ms_tick) begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                if (ms_tick) begin
                    state_n = (cnt == '0) ? PICK : DOWN;
                    cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
                end
            end
        endcase
        // leaving the round freezes score and mole history; the final score stays readable
        if (state != IDLE && !game_in_progress) begin
            state_n = IDLE;
            cnt_n   = cnt;
            prev_n  = prev_idx;
            score_n = score;
            hit_n   = 1'b0;
            miss_n  = 1'b0;
        end
        mask_n = (state_n == UP) ? {{(NUM_HOLES-1){1'b0}}, 1'b1} << prev_n : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            btn_q      <= '0;
            prev_idx   <= '0;
            cnt        <= '0;
            score      <= '0;
            mole_mask  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            mole_up    <= 1'b0;
        end else begin
            state      <= state_n;
            lfsr       <= lfsr_n;
            btn_q      <= buttons;
            prev_idx   <= prev_n;
            cnt        <= cnt_n;
            score      <= score_n;
            mole_mask  <= mask_n;
            hit_pulse  <= hit_n;
            miss_pulse <= miss_n;
            mole_up    <= (state_n == UP);
        end
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed checks of mole timing, hits, misses, saturation and abort.
module tb_mole_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ms_tick = 1'b0;
    logic       game_in_progress = 1'b0;
    logic [3:0] buttons = '0;
    logic [3:0] mole_mask;
    logic [3:0] score;
    logic       hit_pulse, miss_pulse, mole_up;

    int errors = 0;
    int checks = 0;
    int tc = 0;
    int exp_score = 0;

    mole_scheduler #(
        .NUM_HOLES(4), .MOLE_UP_MS(4), .MOLE_DOWN_MS(2), .SCORE_W(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .game_in_progress(game_in_progress),
        .buttons(buttons), .mole_mask(mole_mask), .score(score),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .mole_up(mole_up)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        tc = (tc == 4) ? 0 : tc + 1;
        ms_tick = (tc == 4);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_up();
        int g = 0;
        while (mole_up && g < 200) begin step(); g++; end
        while (!mole_up && g < 200) begin step(); g++; end
        chk("wait_up_bound", 32'(g < 200), 1);
    endtask

    task automatic hit_active(input string tag);
        buttons = mole_mask;
        step();
        chk(tag, hit_pulse, 1);
        buttons = '0;
        exp_score = (exp_score == 15) ? 15 : exp_score + 1;
    endtask

    initial begin
        logic [3:0] m, prev;
        int upt, dnt, upul, dpul, bad, n, g;
        prev = '0;
        // reset held with the game already requested
        game_in_progress = 1'b1;
        repeat (3) step();
        chk("rst_mask", mole_mask, 0);
        chk("rst_score", score, 0);
        chk("rst_hit", hit_pulse, 0);
        chk("rst_miss", miss_pulse, 0);
        chk("rst_up", mole_up, 0);
        rst_n = 1'b1;
        step();
        chk("pick_mask", mole_mask, 0);
        chk("pick_up", mole_up, 0);
        step();
        // seed ACE1 advances once to E270: raw 0 equals prev 0, so hole 1
        chk("first_mask", mole_mask, 4'b0010);
        chk("first_up", mole_up, 1);
        // escapes: 50 moles without presses
        for (int k = 0; k < 50; k++) begin
            m = mole_mask;
            chk("esc_onehot", 32'($onehot(m)), 1);
            if (k > 0) chk("esc_differs", 32'(m != prev), 1);
            prev = m;
            upt = 0; dnt = 0; upul = 0; dpul = 0; bad = 0; g = 0;
            while (mole_up && g < 100) begin
                if (ms_tick) upt++;
                if (mole_mask != m) bad++;
                step(); g++;
                if (miss_pulse) upul++;
                if (hit_pulse) upul += 10;
            end
            while (!mole_up && g < 200) begin
                if (ms_tick) dnt++;
                if (mole_mask != 0) bad++;
                step(); g++;
                if (miss_pulse || hit_pulse) dpul++;
            end
            chk("esc_up_ticks", upt, 4);
            chk("esc_miss", upul, 1);
            chk("esc_down_ticks", dnt, 2);
            chk("esc_mask_shape", bad, 0);
            chk("esc_down_pulses", dpul, 0);
        end
        // hit after the first tick, then hold the button
        m = mole_mask;
        n = 0;
        while (n < 1) begin if (ms_tick) n++; step(); end
        buttons = m;
        step();
        exp_score = 1;
        chk("hit_pulse", hit_pulse, 1);
        chk("hit_nomiss", miss_pulse, 0);
        chk("hit_score", score, 1);
        chk("hit_mask", mole_mask, 0);
        chk("hit_up", mole_up, 0);
        step();
        chk("hit_one_clk", hit_pulse, 0);
        n = 0;
        repeat (19) begin step(); if (hit_pulse) n++; end
        chk("hold_no_repeat", n, 0);
        chk("hold_score", score, 1);
        buttons = '0;
        // wrong press during UP
        wait_up();
        m = mole_mask;
        buttons = {m[2:0], m[3]};
        step();
        chk("wrong_miss", miss_pulse, 1);
        chk("wrong_nohit", hit_pulse, 0);
        chk("wrong_up", mole_up, 1);
        chk("wrong_mask", mole_mask, m);
        chk("wrong_score", score, exp_score);
        buttons = '0;
        step();
        chk("wrong_one_clk", miss_pulse, 0);
        g = 0;
        while (mole_up && g < 100) begin step(); g++; end
        chk("wrong_esc_bound", 32'(g < 100), 1);
        // presses while resting are ignored
        buttons = 4'hF;
        step();
        chk("down_press", {30'b0, hit_pulse, miss_pulse}, 0);
        buttons = '0;
        step();
        chk("down_release", {30'b0, hit_pulse, miss_pulse}, 0);
        chk("down_score", score, exp_score);
        // active press on the timeout tick: hit wins
        wait_up();
        m = mole_mask;
        n = 0;
        while (n < 3) begin if (ms_tick) n++; step(); end
        while (!ms_tick) step();
        buttons = m;
        step();
        buttons = '0;
        exp_score++;
        chk("tie_hit", hit_pulse, 1);
        chk("tie_nomiss", miss_pulse, 0);
        chk("tie_score", score, exp_score);
        // saturation
        for (int i = 0; i < 16; i++) begin
            wait_up();
            hit_active("sat_hit");
        end
        chk("sat_score", score, 15);
        // drop and restart, score 3, abort mid-UP
        game_in_progress = 1'b0;
        step(); step();
        chk("stop_mask", mole_mask, 0);
        chk("stop_score", score, 15);
        game_in_progress = 1'b1;
        step();
        exp_score = 0;
        chk("restart_clear", score, 0);
        for (int i = 0; i < 3; i++) begin
            wait_up();
            hit_active("three_hit");
        end
        wait_up();
        step(); step();
        game_in_progress = 1'b0;
        step();
        chk("abort_mask", mole_mask, 0);
        chk("abort_up", mole_up, 0);
        chk("abort_score", score, 3);
        chk("abort_pulses", {30'b0, hit_pulse, miss_pulse}, 0);
        repeat (3) step();
        chk("idle_score", score, 3);
        chk("idle_mask", mole_mask, 0);
        game_in_progress = 1'b1;
        step();
        chk("rerun_clear", score, 0);
        step();
        chk("rerun_up", mole_up, 1);
        chk("rerun_onehot", 32'($onehot(mole_mask)), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
